// File: rtl/ps2_pkg.sv
// Shared scan codes, one-hot headings, frame FSM states and the key decode helper.
// Build option PS2_ARROW_KEYS_EN lets the extended arrow keys steer as well as WASD.
package ps2_pkg;

    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;

    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    // DIR_NONE means "this key does not steer"; callers keep the old heading.
    function automatic logic [3:0] decode_key(input logic [7:0] sc, input logic ext);
        logic [3:0] dir;
        dir = DIR_NONE;
        if (!ext) begin
            case (sc)
                SC_W:    dir = DIR_UP;
                SC_A:    dir = DIR_LEFT;
                SC_S:    dir = DIR_DOWN;
                SC_D:    dir = DIR_RIGHT;
                default: dir = DIR_NONE;
            endcase
        end
`ifdef PS2_ARROW_KEYS_EN
        else begin
            case (sc)
                SC_UP:    dir = DIR_UP;
                SC_LEFT:  dir = DIR_LEFT;
                SC_DOWN:  dir = DIR_DOWN;
                SC_RIGHT: dir = DIR_RIGHT;
                default:  dir = DIR_NONE;
            endcase
        end
`endif
        return dir;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizer, falling-edge detect, start/parity/stop check, bit-gap timeout.
// Latency: byte_valid/frame_err are combinational strobes in the stop-edge (or timeout) cycle.
// Backpressure: none; a PS/2 device cannot be stalled, so every strobe must be consumed that cycle.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       VGA_clk,
    input  logic       reset,
    input  logic       KB_clk,
    input  logic       KB_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic         kb_clk_meta, kb_clk_sync, kb_clk_prev;
    logic         kb_data_meta, kb_data_sync;
    frame_state_t state, state_nxt;
    logic [2:0]   bit_cnt, bit_cnt_nxt;
    logic [7:0]   shift, shift_nxt;
    logic         parity_bit, parity_nxt;
    logic [15:0]  tmo_cnt, tmo_nxt;
    logic         fall_edge, timeout;

    // Idle PS/2 lines are high, so the synchronizers reset to 1 to avoid a phantom edge.
    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            kb_clk_meta  <= 1'b1;
            kb_clk_sync  <= 1'b1;
            kb_clk_prev  <= 1'b1;
            kb_data_meta <= 1'b1;
            kb_data_sync <= 1'b1;
            state        <= ST_IDLE;
            bit_cnt      <= 3'd0;
            shift        <= 8'd0;
            parity_bit   <= 1'b0;
            tmo_cnt      <= 16'd0;
        end else begin
            kb_clk_meta  <= KB_clk;
            kb_clk_sync  <= kb_clk_meta;
            kb_clk_prev  <= kb_clk_sync;
            kb_data_meta <= KB_data;
            kb_data_sync <= kb_data_meta;
            state        <= state_nxt;
            bit_cnt      <= bit_cnt_nxt;
            shift        <= shift_nxt;
            parity_bit   <= parity_nxt;
            tmo_cnt      <= tmo_nxt;
        end
    end

    assign fall_edge = kb_clk_prev & ~kb_clk_sync;
    assign timeout   = (state != ST_IDLE) && !fall_edge && (tmo_cnt == TMO_LAST);
    assign rx_byte   = shift;

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        parity_nxt  = parity_bit;
        byte_valid  = 1'b0;
        frame_err   = 1'b0;
        tmo_nxt     = (state == ST_IDLE || fall_edge) ? 16'd0 : tmo_cnt + 16'd1;

        case (state)
            ST_IDLE: begin
                if (fall_edge) begin
                    if (!kb_data_sync) begin
                        state_nxt   = ST_DATA;
                        bit_cnt_nxt = 3'd0;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (fall_edge) begin
                    shift_nxt   = {kb_data_sync, shift[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (fall_edge) begin
                    parity_nxt = kb_data_sync;
                    state_nxt  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall_edge) begin
                    if (kb_data_sync && (^{shift, parity_bit})) byte_valid = 1'b1;
                    else                                        frame_err  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (timeout) begin
            frame_err = 1'b1;
            state_nxt = ST_IDLE;
        end
    end

endmodule

// File: rtl/ps2_direction_decoder.sv
// PS/2 keyboard to one-hot Snake heading, tracking E0/F0 prefixes; PS2_ARROW_KEYS_EN adds arrow keys.
// Latency: code/code_valid/frame_err/direction register one cycle after the stop-bit edge cycle.
// Backpressure: none; the game core samples direction whenever it likes, pulses are not held.
module ps2_direction_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       VGA_clk,
    input  logic       reset,
    input  logic       KB_clk,
    input  logic       KB_data,
    output logic [3:0] direction,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_vld;
    logic       rx_err;
    logic       ext, brk;
    logic [3:0] key_dir;

    ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_frame_rx (
        .VGA_clk    (VGA_clk),
        .reset      (reset),
        .KB_clk     (KB_clk),
        .KB_data    (KB_data),
        .rx_byte    (rx_byte),
        .byte_valid (rx_vld),
        .frame_err  (rx_err)
    );

    assign key_dir = decode_key(rx_byte, ext);

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            direction  <= DIR_NONE;
            code       <= 8'd0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            ext        <= 1'b0;
            brk        <= 1'b0;
        end else begin
            code_valid <= rx_vld;
            frame_err  <= rx_err;
            if (rx_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (rx_vld) begin
                code <= rx_byte;
                if (rx_byte == SC_EXT) begin
                    ext <= 1'b1;
                end else if (rx_byte == SC_BRK) begin
                    brk <= 1'b1;
                end else begin
                    // Key byte: releases never steer; unmapped keys keep the old heading.
                    if (!brk && key_dir != DIR_NONE) direction <= key_dir;
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Directed bench for ps2_direction_decoder with a scaled-down PS/2 bit period and timeout.
module tb_ps2_direction_decoder;

    localparam int TMO  = 1000;
    localparam int QTR  = 25;    // bit period = 4*QTR cycles, edges 100 cycles apart

    logic       VGA_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       KB_clk  = 1'b1;
    logic       KB_data = 1'b1;
    logic [3:0] direction;
    logic [7:0] code;
    logic       code_valid;
    logic       frame_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_err = 0;
    int last_valid_cyc = 0;
    int last_err_cyc = 0;
    int last_fall = 0;
    logic [3:0] dir_at_valid = 4'b0;

    ps2_direction_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .VGA_clk    (VGA_clk),
        .reset      (reset),
        .KB_clk     (KB_clk),
        .KB_data    (KB_data),
        .direction  (direction),
        .code       (code),
        .code_valid (code_valid),
        .frame_err  (frame_err)
    );

    always #5 VGA_clk = ~VGA_clk;
    always @(posedge VGA_clk) cyc <= cyc + 1;

    always @(negedge VGA_clk) begin
        if (code_valid) begin
            n_valid++;
            last_valid_cyc = cyc;
            dir_at_valid   = direction;
        end
        if (frame_err) begin
            n_err++;
            last_err_cyc = cyc;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge VGA_clk);
        #1;
    endtask

    // Data changes mid-high, then a full low phase, then high again.
    task automatic drive_bit(input logic b);
        wait_cyc(1);
        KB_data = b;
        wait_cyc(QTR);
        KB_clk    = 1'b0;
        last_fall = cyc;
        wait_cyc(2 * QTR);
        KB_clk = 1'b1;
        wait_cyc(QTR - 1);
    endtask

    task automatic send_bits(input logic [7:0] b, input logic flip_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) drive_bit(f[i]);
        KB_data = 1'b1;
        wait_cyc(50);
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_bits(b, 1'b0, 11);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        wait_cyc(5);
        @(negedge VGA_clk);
        checks++; if (direction !== 4'b0000) begin errors++; $display("FAIL reset_dir got=%b exp=0000", direction); end
        checks++; if (code !== 8'h00) begin errors++; $display("FAIL reset_code got=%h exp=00", code); end
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", code_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", frame_err); end
        wait_cyc(1);
        reset = 1'b0;
        wait_cyc(20);
    endtask

    task automatic test_make_w;
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_frame(8'h1D);
        checks++; if (code !== 8'h1D) begin errors++; $display("FAIL w_code got=%h exp=1d", code); end
        checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL w_vld_cnt got=%0d exp=1", n_valid - v0); end
        checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL w_err_cnt got=%0d exp=0", n_err - e0); end
        checks++; if (direction !== 4'b0001) begin errors++; $display("FAIL w_dir got=%b exp=0001", direction); end
        checks++; if (dir_at_valid !== 4'b0001) begin errors++; $display("FAIL w_dir_with_vld got=%b exp=0001", dir_at_valid); end
        // 2 sync flops + edge-detect cycle + output register
        checks++; if (last_valid_cyc - last_fall !== 3) begin errors++; $display("FAIL w_latency got=%0d exp=3", last_valid_cyc - last_fall); end
    endtask

    task automatic test_break;
        int v0;
        v0 = n_valid;
        send_frame(8'hF0);
        send_frame(8'h23);
        checks++; if (direction !== 4'b0001) begin errors++; $display("FAIL brk_dir got=%b exp=0001", direction); end
        send_frame(8'h23);
        checks++; if (direction !== 4'b1000) begin errors++; $display("FAIL brk_make_dir got=%b exp=1000", direction); end
        checks++; if (n_valid - v0 !== 3) begin errors++; $display("FAIL brk_vld_cnt got=%0d exp=3", n_valid - v0); end
        checks++; if (code !== 8'h23) begin errors++; $display("FAIL brk_code got=%h exp=23", code); end
    endtask

    task automatic test_parity;
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_bits(8'h1C, 1'b1, 11);
        checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL par_err_cnt got=%0d exp=1", n_err - e0); end
        checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL par_vld_cnt got=%0d exp=0", n_valid - v0); end
        checks++; if (direction !== 4'b1000) begin errors++; $display("FAIL par_dir got=%b exp=1000", direction); end
        send_frame(8'h1C);
        checks++; if (direction !== 4'b0010) begin errors++; $display("FAIL par_next_dir got=%b exp=0010", direction); end
    endtask

    task automatic test_timeout;
        int e0, fall;
        e0 = n_err;
        send_bits(8'h1B, 1'b0, 5);
        fall = last_fall;
        wait_cyc(TMO + 200);
        checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL tmo_err_cnt got=%0d exp=1", n_err - e0); end
        // edge seen 2 cycles after the pin falls, counter hits TMO-1, then output register
        checks++; if (last_err_cyc - fall !== TMO + 3) begin errors++; $display("FAIL tmo_when got=%0d exp=%0d", last_err_cyc - fall, TMO + 3); end
        send_frame(8'h1B);
        checks++; if (direction !== 4'b0100) begin errors++; $display("FAIL tmo_next_dir got=%b exp=0100", direction); end
        checks++; if (code !== 8'h1B) begin errors++; $display("FAIL tmo_next_code got=%h exp=1b", code); end
    endtask

    task automatic test_extended;
        logic [3:0] exp_arrow;
`ifdef PS2_ARROW_KEYS_EN
        exp_arrow = 4'b0100;
`else
        exp_arrow = 4'b1000;
`endif
        send_frame(8'h23);
        send_frame(8'hE0);
        send_frame(8'h72);
        checks++; if (direction !== exp_arrow) begin errors++; $display("FAIL ext_dir got=%b exp=%b", direction, exp_arrow); end
        send_frame(8'h1C);
        checks++; if (direction !== 4'b0010) begin errors++; $display("FAIL ext_cleared_dir got=%b exp=0010", direction); end
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h72);
        checks++; if (direction !== 4'b0010) begin errors++; $display("FAIL ext_brk_dir got=%b exp=0010", direction); end
        checks++; if (code !== 8'h72) begin errors++; $display("FAIL ext_brk_code got=%h exp=72", code); end
    endtask

    task automatic test_reset_mid_frame;
        int v0;
        send_bits(8'h23, 1'b0, 5);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        @(negedge VGA_clk);
        checks++; if (direction !== 4'b0000) begin errors++; $display("FAIL rst_mid_dir got=%b exp=0000", direction); end
        checks++; if (code !== 8'h00) begin errors++; $display("FAIL rst_mid_code got=%h exp=00", code); end
        v0 = n_valid;
        wait_cyc(1);
        for (int i = 5; i < 11; i++) drive_bit((i == 10) ? 1'b1 : ((i == 9) ? ~^8'h23 : 1'b0) | ((i == 5) ? 1'b1 : 1'b0));
        KB_data = 1'b1;
        wait_cyc(TMO + 200);
        checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL rst_rest_vld got=%0d exp=0", n_valid - v0); end
        checks++; if (direction !== 4'b0000) begin errors++; $display("FAIL rst_rest_dir got=%b exp=0000", direction); end
        send_frame(8'h1B);
        checks++; if (direction !== 4'b0100) begin errors++; $display("FAIL rst_next_dir got=%b exp=0100", direction); end
        checks++; if (code !== 8'h1B) begin errors++; $display("FAIL rst_next_code got=%h exp=1b", code); end
    endtask

    initial begin
        test_reset();
        test_make_w();
        test_break();
        test_parity();
        test_timeout();
        test_extended();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
